// File: rtl/spr_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : spr_fifo_ctrl_pkg
// Brief  : Shared output-FSM state codes for the single-port-RAM FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
package spr_fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PEND  = 2'd1,
        ST_HOLD  = 2'd2
    } fifo_state_e;

endpackage : spr_fifo_ctrl_pkg
`default_nettype wire

// File: rtl/spr_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : spr_fifo_ctrl
// Brief  : FIFO controller over a single-port synchronous-read RAM; reads win
//          arbitration, output is a registered valid/ready stage.
// Rev    : 1.0 - initial release
// ============================================================================
module spr_fifo_ctrl
    import spr_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADD_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADD_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              ram_we,
    output logic [ADD_W-1:0]  ram_add,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int             DEPTH   = 1 << ADD_W;
    localparam logic [ADD_W:0] C_DEPTH = (ADD_W + 1)'(DEPTH);

    fifo_state_e       state_q,     state_d;
    logic [ADD_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [ADD_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [ADD_W:0]    count_q,     count_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;

    logic w_rd_go;
    logic w_full;
    logic w_wr_en;

    // Read decision depends only on registered state, keeping out_ready off the RAM port.
    assign w_rd_go = (state_q == ST_EMPTY) && (count_q != '0);
    assign w_full  = (count_q == C_DEPTH);
    assign w_wr_en = in_valid && !w_full && !w_rd_go;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + ADD_W'(1);
            count_d  = count_q + (ADD_W + 1)'(1);
        end else if (w_rd_go) begin
            rd_ptr_d = rd_ptr_q + ADD_W'(1);
            count_d  = count_q - (ADD_W + 1)'(1);
        end

        case (state_q)
            ST_EMPTY: begin
                if (w_rd_go) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                out_data_d  = ram_dout;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_EMPTY;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = !w_full && !w_rd_go;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign full      = w_full;
    assign empty     = (count_q == '0);
    assign ram_we    = w_wr_en;
    assign ram_add   = w_wr_en ? wr_ptr_q : rd_ptr_q;
    assign ram_din   = in_data;

endmodule : spr_fifo_ctrl
`default_nettype wire

// File: tb/tb_spr_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_spr_fifo_ctrl
// Brief  : Scoreboard bench for spr_fifo_ctrl with a behavioural spr RAM.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_spr_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int ADD_W  = 4;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADD_W:0]    count;
    logic              full;
    logic              empty;
    logic              ram_we;
    logic [ADD_W-1:0]  ram_add;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic [DATA_W-1:0] mem [1 << ADD_W];
    logic [DATA_W-1:0] exp_q [$];
    int                n_checks;
    int                n_fails;
    int                n_pop;
    logic              prod_done;

    spr_fifo_ctrl #(
        .DATA_W (DATA_W),
        .ADD_W  (ADD_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ram_we    (ram_we),
        .ram_add   (ram_add),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: write, or synchronous read one cycle later.
    always @(posedge clk) begin
        if (ram_we) mem[ram_add] <= ram_din;
        else        ram_dout     <= mem[ram_add];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back(in_data);
            if (out_valid && out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) check_val("sb_underflow", 32'd1, 32'd0);
                else                   check_val("order", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push(input logic [DATA_W-1:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check_val("push_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok        = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && !out_valid && (count == '0);
        end
        if (!ok) check_val("drain_timeout", 32'd1, 32'd0);
        check_val("drain_empty", 32'(empty), 32'd1);
        check_val("drain_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        n_pop     = 0;
        prod_done = 1'b0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset asserted mid-clock takes effect immediately.
        #3 rst = 1'b1;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_ram_we", 32'(ram_we), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill with the consumer stalled.
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        @(negedge clk);
        check_val("fill_count15", 32'(count), 32'd15);
        check_val("fill_head_valid", 32'(out_valid), 32'd1);
        check_val("fill_head_data", 32'(out_data), 32'h10);
        @(posedge clk);
        #1;
        push(8'h20);
        @(negedge clk);
        check_val("full_count", 32'(count), 32'd16);
        check_val("full_flag", 32'(full), 32'd1);
        check_val("full_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h21;
        repeat (4) begin
            @(negedge clk);
            check_val("drop_ram_we", 32'(ram_we), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_val("drop_count", 32'(count), 32'd16);
        @(posedge clk);
        #1;
        drain();

        // Read wins against a simultaneous write.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        @(negedge clk);
        check_val("conf_first_ready", 32'(in_ready), 32'd1);
        check_val("conf_first_we", 32'(ram_we), 32'd1);
        @(posedge clk);
        #1;
        in_data = 8'h56;
        @(negedge clk);
        check_val("conf_in_ready", 32'(in_ready), 32'd0);
        check_val("conf_ram_we", 32'(ram_we), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("conf_late_we", 32'(ram_we), 32'd1);
        check_val("conf_late_din", 32'(ram_din), 32'h56);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Latency T+2 and stable backpressure.
        out_ready = 1'b0;
        push(8'h40);
        check_val("lat_t0", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_val("lat_t1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_val("lat_t2_valid", 32'(out_valid), 32'd1);
        check_val("lat_t2_data", 32'(out_data), 32'h40);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_val("bp_valid", 32'(out_valid), 32'd1);
            check_val("bp_data", 32'(out_data), 32'h40);
        end
        drain();

        // Random traffic across several pointer wraps.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    push(8'(i));
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        check_val("total_pops", 32'(n_pop), 32'd60);

        // Reset mid-operation discards buffered data.
        out_ready = 1'b0;
        push(8'h77);
        push(8'h78);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_val("mid_rst_count", 32'(count), 32'd0);
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_empty", 32'(empty), 32'd1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("post_rst_valid", 32'(out_valid), 32'd0);
        check_val("post_rst_count", 32'(count), 32'd0);
        check_val("post_rst_pops", 32'(n_pop), 32'd60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_spr_fifo_ctrl
`default_nettype wire
